// File: rtl/result_display_driver.sv
// result_display_driver
// Captures a signed 8-bit result, converts |value| to three BCD digits with a
// serial shift-add-3 engine, and scans sign/hundreds/tens/ones onto a 4-digit
// active-low 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros in the
// hundreds and tens positions; the ones digit is always shown).
module result_display_driver #(
    parameter int SCAN_DIV = 16,
    parameter int SCAN_W   = 16
) (
    input  logic       clk,
    input  logic       Clear,
    input  logic       res_valid,
    input  logic [7:0] res_in,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_h,
    output logic [3:0] bcd_t,
    output logic [3:0] bcd_o,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [1:0]        state;
    logic              sign_r;
    logic [7:0]        mag;
    logic [11:0]       scratch;
    logic [11:0]       adj;
    logic [2:0]        bit_cnt;
    logic [SCAN_W-1:0] presc;
    logic [1:0]        idx;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Per-nibble correction applied before each shift of the BCD scratch
    always_comb begin
        adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    // A busy flag derived from state keeps busy and done mutually exclusive
    assign busy = (state != S_IDLE);

    // Conversion FSM: capture magnitude, 8 add-3/shift steps, then commit
    always_ff @(posedge clk) begin
        if (Clear) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            sign    <= 1'b0;
            bcd_h   <= 4'd0;
            bcd_t   <= 4'd0;
            bcd_o   <= 4'd0;
            sign_r  <= 1'b0;
            mag     <= 8'd0;
            scratch <= 12'd0;
            bit_cnt <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (res_valid) begin
                        sign_r  <= res_in[7];
                        // 8'h80 negates to 8'h80, which reads as 128 unsigned
                        mag     <= res_in[7] ? (~res_in + 8'd1) : res_in;
                        scratch <= 12'd0;
                        bit_cnt <= 3'd0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= {adj[10:0], mag[7]};
                    mag     <= {mag[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    sign  <= sign_r;
                    bcd_h <= scratch[11:8];
                    bcd_t <= scratch[7:4];
                    bcd_o <= scratch[3:0];
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Scan prescaler and digit index; runs regardless of conversion activity
    always_ff @(posedge clk) begin
        if (Clear) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == SCAN_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + SCAN_W'(1);
        end
    end

    // Digit select and segment decode from the committed registers
    always_comb begin
        an  = 4'b1111;
        seg = SEG_BLANK;
        case (idx)
            2'd0: begin
                an  = 4'b1110;
                seg = seg_digit(bcd_o);
            end
            2'd1: begin
                an  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                seg = (bcd_h == 4'd0 && bcd_t == 4'd0) ? SEG_BLANK : seg_digit(bcd_t);
`else
                seg = seg_digit(bcd_t);
`endif
            end
            2'd2: begin
                an  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                seg = (bcd_h == 4'd0) ? SEG_BLANK : seg_digit(bcd_h);
`else
                seg = seg_digit(bcd_h);
`endif
            end
            default: begin
                an  = 4'b0111;
                seg = sign ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Downstream consumer of the signed calculator result: an 8-bit two's-complement value.
- Captures the result on a valid strobe and converts it to sign + three BCD digits using a serial shift-add-3 (double-dabble) engine.
- Holds the digits and drives a 4-digit, time-multiplexed, active-low 7-segment display: sign, hundreds, tens, ones.
- Sits between the calculator core and the board display pins.

Parameters:
- SCAN_DIV, 16, clock cycles each digit stays lit before the scan advances; legal range ≥2.
- SCAN_W, 16, width of the scan prescaler counter; must satisfy 2^SCAN_W > SCAN_DIV.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- Clear  in  1  synchronous, active-high reset.
- res_valid  in  1  result strobe; res_in is sampled when this is high and the block is idle.
- res_in  in  8  signed two's-complement result.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- sign  out  1  registered sign of the last committed result (1 = negative).
- bcd_h  out  4  hundreds digit, 0..1.
- bcd_t  out  4  tens digit, 0..9.
- bcd_o  out  4  ones digit, 0..9.
- an  out  4  digit enables, active-low: an[3]=sign, an[2]=hundreds, an[1]=tens, an[0]=ones.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (Clear=1 at a posedge, overrides everything):
  - state=IDLE; busy=0, done=0, sign=0, bcd_h/t/o=0.
  - Scan prescaler=0, digit index=0, so an=4'b1110 and seg=7'b1000000 ('0').
  - An in-flight conversion is abandoned; no done pulse follows.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE, res_valid=1:
  - sign_r <= res_in[7].
  - mag <= |res_in| as 8-bit unsigned; -128 (8'h80) gives 128.
  - BCD scratch cleared, bit counter=0, goto SHIFT, busy=1.
- IDLE, res_valid=0: stay.
- SHIFT, once per cycle for 8 cycles:
  - Each scratch nibble ≥5 gets +3.
  - Then shift {scratch,mag} left 1.
  - Counter increments; after the 8th shift goto COMMIT.
- COMMIT:
  - sign/bcd_h/bcd_t/bcd_o <= scratch values.
  - done=1 for exactly this following cycle; busy=0; goto IDLE.
- Latency:
  - res_valid sampled at edge 0 → outputs update and done rises at edge 9.
  - busy is high from edge 0 to edge 9.
  - done and busy are never high together.
- res_valid while busy=1 is ignored; there is no queueing.
- res_valid in the cycle done=1 is accepted (state is IDLE).
- Committed outputs hold until the next COMMIT or Clear.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap, the digit index increments 0→1→2→3→0.
  - an/seg are decoded combinationally from the index and committed registers.
  - Scan runs continuously, independent of conversion; digits switch atomically at COMMIT.
- Index mapping:
  - 0 → ones, an=1110.
  - 1 → tens, an=1101.
  - 2 → hundreds, an=1011.
  - 3 → sign, an=0111.
- Sign digit: seg=7'b0111111 (g only, '-') if sign=1, else 7'b1111111 (blank).
- Digit encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values >9 are impossible; decode as blank.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds position blanks (seg=1111111) when bcd_h=0.
  - Tens position blanks when bcd_h=0 and bcd_t=0.
  - Ones position is never blanked.
  - an scanning is unchanged.
- Undefined: all three numeric positions always show their digit, leading zeros included.
- bcd_* outputs are identical in both builds.

Test Plan:
- Clear for 2 cycles then release → sign=0, bcd=0/0/0, an=1110, seg=1000000, busy=0, done=0.
- res_in=8'h7F, res_valid 1 cycle → done at edge 9; sign=0, bcd_h/t/o=1/2/7.
- res_in=8'h80 → sign=1, 1/2/8; at index 3, seg=0111111. res_in=8'hF6 → sign=1, 0/1/0.
- Pulse 8'h05, then 8'h09 at cycles 3 and 9 → only 5 is committed and done pulses once; 8'h09 pulsed in the done cycle is accepted → 0/0/9 after 9 more edges.
- Clear asserted at cycle 4 of a conversion of 8'h64 → no done; outputs return to reset values; the next 8'h64 gives 1/0/0.
- Committed 8'h07, SCAN_DIV=16 → an steps 1110→1101→1011→0111 every 16 cycles. LEADING_ZERO_BLANK_EN build: hundreds/tens seg=1111111, ones=1111000. Default build: hundreds/tens=1000000.
